// File: rtl/if_id_stage.sv
// Instruction fetch (PC register, ROM address) plus IF/ID pipeline register with halt/resume FSM and saturating perf counters.
// Latency: the word at PC_IF appears on Instr_ID one edge later when the pipeline advances.
// Backpressure: IF_ID_STOP=0 holds PC and IF/ID; an EX redirect overrides a stall; HALTED freezes fetch until Go.
module if_id_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IF_ID_STOP,
    input  logic             Redirect,
    input  logic [PC_W-1:0]  RedirectPC,
    input  logic             Halt,
    input  logic             Go,
    input  logic [PC_W-1:0]  InstrIn,
    output logic [PC_W-1:0]  PC_IF,
    output logic [PC_W-1:0]  PC_ID,
    output logic [PC_W-1:0]  PC4_ID,
    output logic [PC_W-1:0]  Instr_ID,
    output logic             Valid_ID,
    output logic             Halted,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_if_q, pc_if_d;
    logic [PC_W-1:0]  pc_id_q, pc_id_d;
    logic [PC_W-1:0]  instr_id_q, instr_id_d;
    logic             valid_id_q, valid_id_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Counters stick at all-ones so the display never shows a wrapped value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Next-state and datapath selection: halt beats redirect beats stall beats advance.
    always_comb begin
        state_d    = state_q;
        pc_if_d    = pc_if_q;
        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;
        valid_id_d = valid_id_q;
        cyc_d      = cyc_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        case (state_q)
            S_RUN: begin
                cyc_d = sat_inc(cyc_q);
                if (Halt) begin
                    // Freeze fetch at the current PC; any redirect this cycle is dropped.
                    state_d    = S_HALTED;
                    pc_id_d    = '0;
                    instr_id_d = '0;
                    valid_id_d = 1'b0;
                end else if (Redirect) begin
                    // Branch in EX is older than anything in ID, so it wins over a stall.
                    pc_if_d    = RedirectPC;
                    pc_id_d    = '0;
                    instr_id_d = '0;
                    valid_id_d = 1'b0;
                    flush_d    = sat_inc(flush_q);
                end else if (!IF_ID_STOP) begin
                    stall_d = sat_inc(stall_q);
                end else begin
                    pc_if_d    = pc_if_q + PC_STEP;
                    pc_id_d    = pc_if_q;
                    instr_id_d = InstrIn;
                    valid_id_d = 1'b1;
                end
            end
            S_HALTED: begin
                if (Go) begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            pc_if_q    <= RESET_PC;
            pc_id_q    <= '0;
            instr_id_q <= '0;
            valid_id_q <= 1'b0;
            cyc_q      <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_if_q    <= pc_if_d;
            pc_id_q    <= pc_id_d;
            instr_id_q <= instr_id_d;
            valid_id_q <= valid_id_d;
            cyc_q      <= cyc_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign PC_IF    = pc_if_q;
    assign PC_ID    = pc_id_q;
    assign PC4_ID   = pc_id_q + PC_STEP;
    assign Instr_ID = instr_id_q;
    assign Valid_ID = valid_id_q;
    assign Halted   = (state_q == S_HALTED);
    assign CycleCnt = cyc_q;
    assign StallCnt = stall_q;
    assign FlushCnt = flush_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed per-cycle vectors with hand-computed expectations.
// Expectations are queued when a vector is driven and popped by an independent monitor after the edge.
// Counters are 4 bits wide here so saturation is reachable in a short run.
module tb_if_id_stage;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             IF_ID_STOP;
    logic             Redirect;
    logic [PC_W-1:0]  RedirectPC;
    logic             Halt;
    logic             Go;
    logic [PC_W-1:0]  InstrIn;
    logic [PC_W-1:0]  PC_IF;
    logic [PC_W-1:0]  PC_ID;
    logic [PC_W-1:0]  PC4_ID;
    logic [PC_W-1:0]  Instr_ID;
    logic             Valid_ID;
    logic             Halted;
    logic [CNT_W-1:0] CycleCnt;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    if_id_stage #(
        .PC_W    (PC_W),
        .RESET_PC(32'h0000_0000),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IF_ID_STOP(IF_ID_STOP),
        .Redirect  (Redirect),
        .RedirectPC(RedirectPC),
        .Halt      (Halt),
        .Go        (Go),
        .InstrIn   (InstrIn),
        .PC_IF     (PC_IF),
        .PC_ID     (PC_ID),
        .PC4_ID    (PC4_ID),
        .Instr_ID  (Instr_ID),
        .Valid_ID  (Valid_ID),
        .Halted    (Halted),
        .CycleCnt  (CycleCnt),
        .StallCnt  (StallCnt),
        .FlushCnt  (FlushCnt)
    );

    // Instruction ROM model: each word is tagged with its own address.
    assign InstrIn = 32'h2000_0000 | PC_IF;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [31:0] pc_if;
        logic [31:0] pc_id;
        logic [31:0] instr;
        logic        vld;
        logic        hlt;
        int          cyc;
        int          stl;
        int          fl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    // Monitor: after each rising edge, compare the DUT against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("PC_IF",    e.tag, PC_IF,    e.pc_if);
            chk("PC_ID",    e.tag, PC_ID,    e.pc_id);
            chk("PC4_ID",   e.tag, PC4_ID,   e.pc_id + 32'd4);
            chk("Instr_ID", e.tag, Instr_ID, e.instr);
            chk("Valid_ID", e.tag, {31'd0, Valid_ID}, {31'd0, e.vld});
            chk("Halted",   e.tag, {31'd0, Halted},   {31'd0, e.hlt});
            chk("CycleCnt", e.tag, {28'd0, CycleCnt}, e.cyc);
            chk("StallCnt", e.tag, {28'd0, StallCnt}, e.stl);
            chk("FlushCnt", e.tag, {28'd0, FlushCnt}, e.fl);
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic v(input string tag, input logic r, input logic s, input logic rd,
                     input logic [31:0] rpc, input logic h, input logic g,
                     input logic [31:0] epc, input logic [31:0] epcid, input logic [31:0] eins,
                     input logic evld, input logic ehlt, input int ecyc, input int estl, input int efl);
        exp_t e;
        @(negedge clk);
        rst_n      = r;
        IF_ID_STOP = s;
        Redirect   = rd;
        RedirectPC = rpc;
        Halt       = h;
        Go         = g;
        e.tag = tag; e.pc_if = epc; e.pc_id = epcid; e.instr = eins;
        e.vld = evld; e.hlt = ehlt; e.cyc = ecyc; e.stl = estl; e.fl = efl;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; IF_ID_STOP = 1'b1; Redirect = 1'b0; RedirectPC = '0; Halt = 1'b0; Go = 1'b0;

        //  tag        rst stp red rpc            hlt go  PC_IF          PC_ID          Instr_ID       V  H  cyc stl fl
        v("reset0",    0,  1,  0,  32'h0,         0,  0,  32'h0,         32'h0,         32'h0,         0, 0, 0,  0,  0);
        v("reset1",    0,  1,  0,  32'h0,         0,  0,  32'h0,         32'h0,         32'h0,         0, 0, 0,  0,  0);
        v("run1",      1,  1,  0,  32'h0,         0,  0,  32'h4,         32'h0,         32'h2000_0000, 1, 0, 1,  0,  0);
        v("run2",      1,  1,  0,  32'h0,         0,  0,  32'h8,         32'h4,         32'h2000_0004, 1, 0, 2,  0,  0);
        v("run3",      1,  1,  0,  32'h0,         0,  0,  32'hC,         32'h8,         32'h2000_0008, 1, 0, 3,  0,  0);
        v("run4",      1,  1,  0,  32'h0,         0,  0,  32'h10,        32'hC,         32'h2000_000C, 1, 0, 4,  0,  0);
        v("stall1",    1,  0,  0,  32'h0,         0,  0,  32'h10,        32'hC,         32'h2000_000C, 1, 0, 5,  1,  0);
        v("stall2",    1,  0,  0,  32'h0,         0,  0,  32'h10,        32'hC,         32'h2000_000C, 1, 0, 6,  2,  0);
        v("resume",    1,  1,  0,  32'h0,         0,  0,  32'h14,        32'h10,        32'h2000_0010, 1, 0, 7,  2,  0);
        v("redir_stl", 1,  0,  1,  32'h40,        0,  0,  32'h40,        32'h0,         32'h0,         0, 0, 8,  2,  1);
        v("post_red1", 1,  1,  0,  32'h0,         0,  0,  32'h44,        32'h40,        32'h2000_0040, 1, 0, 9,  2,  1);
        v("post_red2", 1,  1,  0,  32'h0,         0,  0,  32'h48,        32'h44,        32'h2000_0044, 1, 0, 10, 2,  1);
        v("redir20",   1,  1,  1,  32'h20,        0,  0,  32'h20,        32'h0,         32'h0,         0, 0, 11, 2,  2);
        v("halt_red",  1,  1,  1,  32'h60,        1,  0,  32'h20,        32'h0,         32'h0,         0, 1, 12, 2,  2);
        v("halted1",   1,  0,  1,  32'h70,        0,  0,  32'h20,        32'h0,         32'h0,         0, 1, 12, 2,  2);
        v("halted2",   1,  1,  1,  32'h70,        0,  0,  32'h20,        32'h0,         32'h0,         0, 1, 12, 2,  2);
        v("halted3",   1,  0,  0,  32'h0,         1,  0,  32'h20,        32'h0,         32'h0,         0, 1, 12, 2,  2);
        v("halted4",   1,  1,  0,  32'h0,         0,  0,  32'h20,        32'h0,         32'h0,         0, 1, 12, 2,  2);
        v("halted5",   1,  0,  1,  32'h70,        1,  0,  32'h20,        32'h0,         32'h0,         0, 1, 12, 2,  2);
        v("go",        1,  1,  0,  32'h0,         0,  1,  32'h20,        32'h0,         32'h0,         0, 0, 12, 2,  2);
        v("refetch20", 1,  1,  0,  32'h0,         0,  0,  32'h24,        32'h20,        32'h2000_0020, 1, 0, 13, 2,  2);
        v("go_in_run", 1,  1,  0,  32'h0,         0,  1,  32'h28,        32'h24,        32'h2000_0024, 1, 0, 14, 2,  2);
        v("cyc15",     1,  1,  0,  32'h0,         0,  0,  32'h2C,        32'h28,        32'h2000_0028, 1, 0, 15, 2,  2);
        v("cyc_sat",   1,  1,  0,  32'h0,         0,  0,  32'h30,        32'h2C,        32'h2000_002C, 1, 0, 15, 2,  2);
        // Twenty stalls push StallCnt from 2 up to its 4-bit ceiling of 15, where it must stick.
        for (int i = 0; i < 20; i++) begin
            v("stall_sat", 1, 0, 0, 32'h0, 0, 0, 32'h30, 32'h2C, 32'h2000_002C, 1, 0, 15,
              (3 + i > 15) ? 15 : 3 + i, 2);
        end
        v("redir_top", 1,  1,  1,  32'hFFFF_FFFC, 0,  0,  32'hFFFF_FFFC, 32'h0,         32'h0,         0, 0, 15, 15, 3);
        v("pc_wrap",   1,  1,  0,  32'h0,         0,  0,  32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 15, 15, 3);
        v("redir80",   1,  1,  1,  32'h80,        0,  0,  32'h80,        32'h0,         32'h0,         0, 0, 15, 15, 4);
        v("halt80",    1,  1,  0,  32'h0,         1,  0,  32'h80,        32'h0,         32'h0,         0, 1, 15, 15, 4);
        v("halted80",  1,  1,  0,  32'h0,         0,  0,  32'h80,        32'h0,         32'h0,         0, 1, 15, 15, 4);
        v("rst_halt",  0,  1,  0,  32'h0,         0,  0,  32'h0,         32'h0,         32'h0,         0, 0, 0,  0,  0);
        v("after_rst", 1,  1,  0,  32'h0,         0,  0,  32'h4,         32'h0,         32'h2000_0000, 1, 0, 1,  0,  0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
